// File: rtl/serial_comp_ctrl_if.sv
// Request/result bundle between a requester and the serial comparator sequencer.
interface serial_comp_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             lt;
   logic             eq;
   logic             gt;
   logic [CW-1:0]    cmp_cycles;

   modport master (
      output start, a, b,
      input  busy, done, lt, eq, gt, cmp_cycles
   );

   modport slave (
      input  start, a, b,
      output busy, done, lt, eq, gt, cmp_cycles
   );
endinterface

// File: rtl/serial_comp_ctrl.sv
// Serial MSB-first magnitude comparator sequencer driving one shared 1-bit
// compare slice (l/e/g). Returns lt/eq/gt plus the number of bit pairs examined,
// with a start/done handshake.
module serial_comp_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input logic               clk,
   input logic               rst,
   serial_comp_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned IW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [IW-1:0]    idx_q;
   logic [CW-1:0]    cnt_q;
   logic             decided_q;
   logic             prime_q;
   logic             lt_r_q;
   logic             gt_r_q;

   logic             busy_q;
   logic             done_q;
   logic             lt_q;
   logic             eq_q;
   logic             gt_q;
   logic [CW-1:0]    cyc_q;

   logic             sl_x;
   logic             sl_y;
   logic             sl_l;
   logic             sl_g;
   logic             sl_e;
   logic             first_d;
   logic             finish_d;
   logic             fin_lt_d;
   logic             fin_gt_d;
   logic [CW-1:0]    cnt_d;

   // Shared 1-bit compare slice on the operand MSBs, plus the decision it implies.
   always_comb begin
      sl_x     = sa_q[WIDTH-1];
      sl_y     = sb_q[WIDTH-1];
      sl_l     = ~sl_x & sl_y;
      sl_g     = sl_x & ~sl_y;
      sl_e     = ~(sl_l | sl_g);
      first_d  = ~decided_q & ~sl_e;
      fin_lt_d = decided_q ? lt_r_q : sl_l;
      fin_gt_d = decided_q ? gt_r_q : sl_g;
      cnt_d    = cnt_q + 1'b1;
      finish_d = (idx_q == '0) || (EARLY_EXIT && first_d);
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sa_q      <= '0;
         sb_q      <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         prime_q   <= 1'b0;
         lt_r_q    <= 1'b0;
         gt_r_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         lt_q      <= 1'b0;
         eq_q      <= 1'b0;
         gt_q      <= 1'b0;
         cyc_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  sa_q      <= bus.a;
                  sb_q      <= bus.b;
                  idx_q     <= IW'(WIDTH - 1);
                  cnt_q     <= '0;
                  decided_q <= 1'b0;
                  prime_q   <= 1'b1;
                  state_q   <= ST_RUN;
                  busy_q    <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               // First RUN cycle only lets the captured operands settle onto the
               // slice inputs; bit evaluation starts on the following edge, which
               // places done one cycle after the last examined bit pair.
               if (prime_q) begin
                  prime_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
                  sa_q  <= sa_q << 1;
                  sb_q  <= sb_q << 1;
                  idx_q <= idx_q - 1'b1;
                  if (first_d) begin
                     lt_r_q    <= sl_l;
                     gt_r_q    <= sl_g;
                     decided_q <= 1'b1;
                  end
                  if (finish_d) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     lt_q    <= fin_lt_d;
                     gt_q    <= fin_gt_d;
                     eq_q    <= ~(fin_lt_d | fin_gt_d);
                     cyc_q   <= cnt_d;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.lt         = lt_q;
   assign bus.eq         = eq_q;
   assign bus.gt         = gt_q;
   assign bus.cmp_cycles = cyc_q;
endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed and randomised checks of serial_comp_ctrl for both EARLY_EXIT settings.
module tb_serial_comp_ctrl;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_pass  = 0;
   int n_total = 0;
   int exp_de  = 0;
   int exp_dc  = 0;
   int dcnt_e  = 0;
   int dcnt_c  = 0;
   int inv_bad = 0;

   serial_comp_ctrl_if #(.WIDTH(W)) ife ();
   serial_comp_ctrl_if #(.WIDTH(W)) ifc ();

   serial_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_e (
      .clk (clk),
      .rst (rst),
      .bus (ife.slave)
   );

   serial_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_c (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   // Count done pulses and watch the one-hot result invariant on both instances.
   always @(negedge clk) begin
      if (!rst) begin
         if (ife.done) dcnt_e++;
         if (ifc.done) dcnt_c++;
         if (int'(ife.lt) + int'(ife.eq) + int'(ife.gt) > 1) inv_bad++;
         if (int'(ifc.lt) + int'(ifc.eq) + int'(ifc.gt) > 1) inv_bad++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   task automatic drive(input bit sel, input bit st, input logic [W-1:0] av,
                        input logic [W-1:0] bv);
      if (sel) begin
         ifc.start = st; ifc.a = av; ifc.b = bv;
      end else begin
         ife.start = st; ife.a = av; ife.b = bv;
      end
   endtask

   function automatic int get_busy(input bit sel);
      return sel ? int'(ifc.busy) : int'(ife.busy);
   endfunction

   function automatic int get_done(input bit sel);
      return sel ? int'(ifc.done) : int'(ife.done);
   endfunction

   // Present start for one edge (accept edge 0) and check the RUN entry.
   task automatic launch(input bit sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input string tag);
      drive(sel, 1'b1, av, bv);
      tick();
      drive(sel, 1'b0, av, bv);
      if (sel) exp_dc++; else exp_de++;
      chk({tag, "_busy0"}, get_busy(sel), 1);
      chk({tag, "_done0"}, get_done(sel), 0);
   endtask

   // Wait (bounded) for done; lat counts edges after the accept edge.
   task automatic wait_done(input bit sel, input int elat, input bit chkbusy, input string tag);
      int lat = 0;
      bit seen = 1'b0;
      while (!seen && lat < 3 * int'(W)) begin
         tick();
         lat++;
         if (get_done(sel) == 1) seen = 1'b1;
         else if (chkbusy) chk({tag, "_busy_run"}, get_busy(sel), 1);
      end
      chk({tag, "_done_seen"}, int'(seen), 1);
      chk({tag, "_latency"}, lat, elat);
   endtask

   task automatic check_res(input bit sel, input int elt, input int eeq, input int egt,
                            input int ecyc, input string tag);
      if (sel) begin
         chk({tag, "_lt"}, int'(ifc.lt), elt);
         chk({tag, "_eq"}, int'(ifc.eq), eeq);
         chk({tag, "_gt"}, int'(ifc.gt), egt);
         chk({tag, "_cyc"}, int'(ifc.cmp_cycles), ecyc);
      end else begin
         chk({tag, "_lt"}, int'(ife.lt), elt);
         chk({tag, "_eq"}, int'(ife.eq), eeq);
         chk({tag, "_gt"}, int'(ife.gt), egt);
         chk({tag, "_cyc"}, int'(ife.cmp_cycles), ecyc);
      end
      chk({tag, "_busy_done"}, get_busy(sel), 0);
   endtask

   task automatic run_cmp(input bit sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int elt, input int eeq, input int egt, input int ecyc,
                          input int elat, input string tag);
      launch(sel, av, bv, tag);
      wait_done(sel, elat, 1'b0, tag);
      check_res(sel, elt, eeq, egt, ecyc, tag);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int k;
      int m;

      drive(1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, '0, '0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      for (int s = 0; s < 2; s++) begin
         check_res(s[0], 0, 0, 0, 0, s == 0 ? "rst_e" : "rst_c");
         chk(s == 0 ? "rst_e_done" : "rst_c_done", get_done(s[0]), 0);
      end

      // 1: equal operands, full scan; busy checked on every RUN edge
      launch(1'b0, 8'hA5, 8'hA5, "t1");
      wait_done(1'b0, 9, 1'b1, "t1");
      check_res(1'b0, 0, 1, 0, 8, "t1");

      // 2: early exit at MSB, then a difference at LSB
      run_cmp(1'b0, 8'h80, 8'h7F, 0, 0, 1, 1, 2, "t2a");
      run_cmp(1'b0, 8'h12, 8'h13, 1, 0, 0, 8, 9, "t2b");

      // 3: constant latency; lower bits (a<b) must not overwrite gt
      run_cmp(1'b1, 8'h80, 8'h7F, 0, 0, 1, 8, 9, "t3");

      // 4: start and operand changes during RUN are ignored
      launch(1'b0, 8'h5A, 8'h59, "t4a");
      tick();
      tick();
      drive(1'b0, 1'b1, 8'h00, 8'hFF);
      tick();
      drive(1'b0, 1'b0, 8'h00, 8'hFF);
      chk("t4a_busy_ign", get_busy(1'b0), 1);
      chk("t4a_hold_lt", int'(ife.lt), 1);
      wait_done(1'b0, 5, 1'b1, "t4a");
      check_res(1'b0, 0, 0, 1, 7, "t4a");
      // back-to-back start on the done cycle
      launch(1'b0, 8'h01, 8'h02, "t4b");
      chk("t4b_hold_gt", int'(ife.gt), 1);
      wait_done(1'b0, 8, 1'b1, "t4b");
      check_res(1'b0, 1, 0, 0, 7, "t4b");

      // 5: reset at edge 3 of a RUN, with start high during reset
      drive(1'b0, 1'b1, 8'h0F, 8'h0E);
      tick();
      drive(1'b0, 1'b0, 8'h0F, 8'h0E);
      tick();
      tick();
      rst = 1'b1;
      drive(1'b0, 1'b1, 8'h0F, 8'h0E);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h0F, 8'h0E);
      check_res(1'b0, 0, 0, 0, 0, "t5");
      chk("t5_done", get_done(1'b0), 0);
      for (int i = 0; i < 12; i++) tick();
      chk("t5_idle_busy", get_busy(1'b0), 0);
      chk("t5_no_done", get_done(1'b0), 0);
      check_res(1'b0, 0, 0, 0, 0, "t5_after");

      // 6: randomised pairs against a reference compare, both settings
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
               0:       rb = ra;
               1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
               default: rb = W'($urandom);
            endcase
            k = -1;
            for (int j = W - 1; j >= 0; j--) begin
               if (k < 0 && ra[j] != rb[j]) k = j;
            end
            if (s == 0) m = (k < 0) ? int'(W) : int'(W) - k;
            else        m = int'(W);
            run_cmp(s[0], ra, rb, int'(ra < rb), int'(ra == rb), int'(ra > rb),
                    m, m + 1, s == 0 ? "rnd_e" : "rnd_c");
         end
         drive(s[0], 1'b0, '0, '0);
         tick();
      end

      tick();
      @(negedge clk);
      chk("done_count_e", dcnt_e, exp_de);
      chk("done_count_c", dcnt_c, exp_dc);
      chk("onehot_invariant", inv_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
